// File: rtl/bcd_counter_ndigit_if.sv
`default_nettype none
// ============================================================================
// Module  : bcd_counter_ndigit_if
// Purpose : Control/data bundle for the N-digit BCD counter.
// Signals : en, up, load, d[4*DIGITS] -> counter ;
//           q[4*DIGITS], tc, load_err <- counter
// Revision: 1.0 - initial release
// ============================================================================
interface bcd_counter_ndigit_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  load_err;

  // Controller side: drives the controls, observes the count.
  modport master (
    output en, up, load, d,
    input  q, tc, load_err
  );

  // Counter side.
  modport slave (
    input  en, up, load, d,
    output q, tc, load_err
  );
endinterface
`default_nettype wire

// File: rtl/bcd_counter_ndigit.sv
`default_nettype none
// ============================================================================
// Module  : bcd_counter_ndigit
// Purpose : Parametrised N-digit BCD up/down counter with synchronous parallel
//           load and a combinational cascade terminal-count output.
// Ports   : clk      - rising-edge clock
//           clear_n  - synchronous active-low clear
//           bus      - slave modport: en, up, load, d in; q, tc, load_err out
//                      (digit i at bits [4*i+3:4*i], digit 0 least significant)
// Revision: 1.0 - initial release
// ============================================================================
module bcd_counter_ndigit #(
  parameter int DIGITS = 2
) (
  input  wire logic              clk,
  input  wire logic              clear_n,
  bcd_counter_ndigit_if.slave    bus
);

  localparam int WIDTH = 4 * DIGITS;

  logic [WIDTH-1:0] count_reg;
  logic             err_reg;

  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] load_value;
  logic             load_bad;
  logic             chain_up;   // all digits seen so far are 9
  logic             chain_dn;   // all digits seen so far are 0
  logic [3:0]       cur_digit;
  logic [3:0]       in_digit;

  // Ripple the "all lower digits at limit" condition from digit 0 upward;
  // after the loop the chains double as the all-9s / all-0s detectors.
  always_comb begin
    chain_up   = 1'b1;
    chain_dn   = 1'b1;
    load_bad   = 1'b0;
    count_next = '0;
    load_value = '0;
    cur_digit  = '0;
    in_digit   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_digit = count_reg[4*i +: 4];
      if (bus.up) begin
        if (chain_up)
          count_next[4*i +: 4] = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        else
          count_next[4*i +: 4] = cur_digit;
      end else begin
        if (chain_dn)
          count_next[4*i +: 4] = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
        else
          count_next[4*i +: 4] = cur_digit;
      end
      chain_up = chain_up & (cur_digit == 4'd9);
      chain_dn = chain_dn & (cur_digit == 4'd0);

      // Non-BCD load digits are squashed to 0 and flagged.
      in_digit = bus.d[4*i +: 4];
      if (in_digit > 4'd9) begin
        load_bad             = 1'b1;
        load_value[4*i +: 4] = 4'd0;
      end else begin
        load_value[4*i +: 4] = in_digit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else if (bus.load) begin
      count_reg <= load_value;
      err_reg   <= load_bad;
    end else begin
      err_reg <= 1'b0;
      if (bus.en)
        count_reg <= count_next;
    end
  end

  assign bus.q        = count_reg;
  assign bus.load_err = err_reg;
  // High in the cycle before the wrap edge so a downstream en can use it directly.
  assign bus.tc       = bus.en & ~bus.load & clear_n &
                        (bus.up ? chain_up : chain_dn);

endmodule
`default_nettype wire
